// File: rtl/zx_mem_pkg.sv
// rtl/zx_mem_pkg.sv - shared SRAM arbiter types and constants
package zx_mem_pkg;

    // Access sequencer states; every state but IDLE lasts exactly one cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } mem_state_t;

    // Requester identities
    typedef enum logic [1:0] {
        REQ_VID = 2'd0,
        REQ_CPU = 2'd1,
        REQ_DMA = 2'd2
    } req_id_t;

    // SRAM byte address of video byte 0
    localparam logic [17:0] VID_BASE_DEFAULT = 18'h04000;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - priority/starvation winner selection
module sram_arb_pick
    import zx_mem_pkg::*;
(
    input  logic    vid_req,
    input  logic    cpu_req,
    input  logic    dma_req,
    input  logic    dma_starved,
    output logic    valid,
    output req_id_t winner
);

    // Video always first; a starved loader jumps ahead of the CPU only
    always_comb begin
        valid  = 1'b1;
        winner = REQ_VID;
        if (vid_req) begin
            winner = REQ_VID;
        end else if (dma_req && (dma_starved || !cpu_req)) begin
            winner = REQ_DMA;
        end else if (cpu_req) begin
            winner = REQ_CPU;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-port async SRAM arbiter and access sequencer
module sram_arbiter
    import zx_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 15,
    parameter logic [17:0] VID_BASE     = VID_BASE_DEFAULT
) (
    input  logic        clk_vram,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_nwait,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [17:0] sram_addr,
    output logic [7:0]  sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    mem_state_t    state;
    mem_state_t    state_nxt;
    req_id_t       owner;
    logic          owner_we;
    logic [SW-1:0] starve_cnt;
    logic          in_hold;
    logic          m_vid;
    logic          m_cpu;
    logic          m_dma;
    logic          pick_valid;
    req_id_t       pick_id;
    logic          grant;

    // The port being acked this cycle sits out arbitration so a held req is not re-served
    assign in_hold = (state == HOLD);
    assign m_vid   = vid_req && !(in_hold && owner == REQ_VID);
    assign m_cpu   = cpu_req && !(in_hold && owner == REQ_CPU);
    assign m_dma   = dma_req && !(in_hold && owner == REQ_DMA);

    sram_arb_pick u_pick (
        .vid_req     (m_vid),
        .cpu_req     (m_cpu),
        .dma_req     (m_dma),
        .dma_starved (starve_cnt >= STARVE_MAX),
        .valid       (pick_valid),
        .winner      (pick_id)
    );

    assign grant = pick_valid && (state == IDLE || state == HOLD);

    // State register
    always_ff @(posedge clk_vram or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: fixed SETUP/STROBE/HOLD walk, new access chained straight from HOLD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = grant ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch winner's address, direction and data at grant; stable for the whole access
    always_ff @(posedge clk_vram or posedge reset) begin
        if (reset) begin
            owner       <= REQ_VID;
            owner_we    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else if (grant) begin
            owner <= pick_id;
            case (pick_id)
                REQ_CPU: begin
                    owner_we    <= cpu_we;
                    sram_addr   <= {2'b00, cpu_addr};
                    sram_dq_out <= cpu_wdata;
                end
                REQ_DMA: begin
                    owner_we    <= dma_we;
                    sram_addr   <= {2'b00, dma_addr};
                    sram_dq_out <= dma_wdata;
                end
                default: begin
                    owner_we    <= 1'b0;
                    sram_addr   <= VID_BASE + {5'b00000, vid_addr};
                    sram_dq_out <= '0;
                end
            endcase
        end
    end

    // Count arbitrations the loader loses, saturating; a loader grant clears it
    always_ff @(posedge clk_vram or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (pick_id == REQ_DMA)
                starve_cnt <= '0;
            else if (m_dma && starve_cnt < STARVE_MAX)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Capture read data into the owner's register as STROBE ends
    always_ff @(posedge clk_vram or posedge reset) begin
        if (reset) begin
            vid_rdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else if (state == STROBE && !owner_we) begin
            case (owner)
                REQ_VID: vid_rdata <= sram_dq_in;
                REQ_CPU: cpu_rdata <= sram_dq_in;
                REQ_DMA: dma_rdata <= sram_dq_in;
                default: ;
            endcase
        end
    end

    assign sram_ce_n  = (state == IDLE);
    assign sram_oe_n  = !((state == STROBE || state == HOLD) && !owner_we);
    assign sram_we_n  = !(state == STROBE && owner_we);
    assign sram_dq_oe = (state != IDLE) && owner_we;

    assign vid_ack   = in_hold && owner == REQ_VID;
    assign cpu_ack   = in_hold && owner == REQ_CPU;
    assign dma_ack   = in_hold && owner == REQ_DMA;
    assign cpu_nwait = !(cpu_req && !cpu_ack);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk_vram = 1'b0;
    logic        reset = 1'b1;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_nwait;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [17:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    sram_arbiter dut (
        .clk_vram    (clk_vram),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (vid_ack),
        .vid_rdata   (vid_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_nwait   (cpu_nwait),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk_vram = ~clk_vram;

    // Async SRAM model
    logic [7:0] mem [0:262143];
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hFF;
    always @(negedge clk_vram)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;

    typedef struct {
        int          id;
        logic        chk;
        logic [7:0]  data;
        logic [17:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   we_low_cnt = 0;
    int   dq_oe_cnt = 0;
    int   oe_low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int who);
        case (who)
            0:       return vid_ack;
            1:       return cpu_ack;
            default: return dma_ack;
        endcase
    endfunction

    task automatic push(input int id, input logic chk, input logic [7:0] d, input logic [17:0] a);
        exp_t e;
        e.id = id; e.chk = chk; e.data = d; e.addr = a;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_vram);
        #1;
    endtask

    task automatic wait_ack(input int who, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_vram);
            if (ack_of(who)) begin
                at_cyc = cyc;
                return;
            end
        end
        check("ack_timeout", 32'(ack_of(who)), 32'd1);
    endtask

    always @(posedge clk_vram) cyc <= cyc + 1;

    // Scoreboard monitor: pop expected access on every ack
    always @(negedge clk_vram) begin
        exp_t        e;
        int          got_id;
        logic [7:0]  rd;
        if (!reset) begin
            if (!sram_we_n) we_low_cnt++;
            if (sram_dq_oe) dq_oe_cnt++;
            if (!sram_oe_n) oe_low_cnt++;
            if (vid_ack || cpu_ack || dma_ack) begin
                ack_cnt++;
                check("ack_onehot", 32'(vid_ack) + 32'(cpu_ack) + 32'(dma_ack), 32'd1);
                got_id = vid_ack ? 0 : (cpu_ack ? 1 : 2);
                rd = vid_ack ? vid_rdata : (cpu_ack ? cpu_rdata : dma_rdata);
                if (sb.size() == 0) begin
                    check("spurious_ack_id", 32'(got_id), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("ack_id", 32'(got_id), 32'(e.id));
                    check("ack_addr", 32'(sram_addr), 32'(e.addr));
                    if (e.chk) check("ack_rdata", 32'(rd), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int t0, ta, tb2, nw_bad, base;

        mem[18'h08123] = 8'hA5;
        mem[18'h04010] = 8'h11;
        mem[18'h04567] = 8'h22;
        mem[18'h0C000] = 8'h00;
        mem[18'h04000] = 8'hB1;
        mem[18'h05000] = 8'hC2;
        mem[18'h06000] = 8'hD3;
        mem[18'h04100] = 8'h77;

        // Reset state
        tick(); tick();
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
        check("rst_rdata", 32'({vid_rdata, cpu_rdata, dma_rdata}), 32'd0);
        reset = 1'b0;
        tick();

        // S1: single CPU read
        push(1, 1'b1, 8'hA5, 18'h08123);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8123;
        t0 = cyc; nw_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_vram);
            if (cpu_ack) break;
            if (cpu_nwait) nw_bad++;
        end
        check("s1_ack_seen", 32'(cpu_ack), 32'd1);
        check("s1_latency", cyc - t0, 32'd3);
        check("s1_nwait_low_before_ack", nw_bad, 32'd0);
        check("s1_nwait_at_ack", 32'(cpu_nwait), 32'd1);
        tick();
        check("s1_ack_one_cycle", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        tick();

        // S2: video and CPU in the same cycle
        push(0, 1'b1, 8'h11, 18'h04010);
        push(1, 1'b1, 8'h22, 18'h04567);
        vid_req = 1'b1; vid_addr = 13'h0010;
        cpu_req = 1'b1; cpu_addr = 16'h4567;
        t0 = cyc;
        wait_ack(0, ta);
        check("s2_vid_latency", ta - t0, 32'd3);
        tick();
        vid_req = 1'b0;
        wait_ack(1, tb2);
        check("s2_cpu_after_vid", tb2 - ta, 32'd3);
        tick();
        cpu_req = 1'b0;
        tick();

        // S3: DMA write then read back
        we_low_cnt = 0; dq_oe_cnt = 0; oe_low_cnt = 0;
        push(2, 1'b0, 8'h00, 18'h0C000);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hC000; dma_wdata = 8'h3C;
        wait_ack(2, ta);
        tick();
        dma_req = 1'b0; dma_we = 1'b0;
        tick(); tick();
        check("s3_we_low_cycles", we_low_cnt, 32'd1);
        check("s3_dq_oe_cycles", dq_oe_cnt, 32'd3);
        check("s3_oe_low_cycles", oe_low_cnt, 32'd0);
        check("s3_mem", 32'(mem[18'h0C000]), 32'h3C);
        check("s3_rdata_kept", 32'(dma_rdata), 32'd0);
        push(2, 1'b1, 8'h3C, 18'h0C000);
        dma_req = 1'b1;
        wait_ack(2, ta);
        tick();
        dma_req = 1'b0;
        tick();

        // S4: video and CPU alternate until the loader's starvation limit is reached
        vid_addr = 13'h0000; cpu_addr = 16'h5000; dma_addr = 16'h6000;
        for (int g = 1; g <= 15; g++) begin
            if (g % 2 == 1) push(0, 1'b1, 8'hB1, 18'h04000);
            else            push(1, 1'b1, 8'hC2, 18'h05000);
        end
        push(2, 1'b1, 8'hD3, 18'h06000);
        push(0, 1'b1, 8'hB1, 18'h04000);
        push(1, 1'b1, 8'hC2, 18'h05000);
        push(0, 1'b1, 8'hB1, 18'h04000);
        base = ack_cnt;
        vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 200 && ack_cnt < base + 18; i++) @(negedge clk_vram);
        tick();
        vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 20 && ack_cnt < base + 19; i++) @(negedge clk_vram);
        tick(); tick();
        check("s4_ack_count", ack_cnt - base, 32'd19);
        check("s4_sb_drained", sb.size(), 32'd0);

        // S5: reset during STROBE of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h7000; cpu_wdata = 8'h99;
        tick();
        check("s5_setup_dq_oe", 32'(sram_dq_oe), 32'd1);
        tick();
        check("s5_in_strobe_we_n", 32'(sram_we_n), 32'd0);
        base = ack_cnt;
        reset = 1'b1;
        #1;
        check("s5_rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("s5_rst_we_n", 32'(sram_we_n), 32'd1);
        check("s5_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("s5_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("s5_rst_cpu_ack", 32'(cpu_ack), 32'd0);
        tick(); tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        reset = 1'b0;
        tick(); tick();
        check("s5_idle_after", 32'(sram_ce_n), 32'd1);
        check("s5_no_ack", ack_cnt - base, 32'd0);

        // S6: req held one cycle past ack
        push(1, 1'b1, 8'h77, 18'h04100);
        push(1, 1'b1, 8'h77, 18'h04100);
        cpu_req = 1'b1; cpu_addr = 16'h4100;
        wait_ack(1, ta);
        tick();
        check("s6_no_regrant_hold", 32'(sram_ce_n), 32'd1);
        tick();
        check("s6_regrant_idle", 32'(sram_ce_n), 32'd0);
        cpu_req = 1'b0;
        wait_ack(1, tb2);
        check("s6_second_ack_gap", tb2 - ta, 32'd4);
        tick(); tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
